// File: rtl/rob_defs.sv
// rob_defs: shared ROB result type, writeback requester count and requester id type.
package rob_defs;
  localparam int WB_NUM_REQ = 3;
  typedef logic [$clog2(WB_NUM_REQ)-1:0] t_wb_req_id;
  typedef struct packed {
    logic [5:0]  robid;
    logic        exc;
    logic [31:0] data;
  } t_rob_result;
endpackage

// File: rtl/rob_wb_fifo.sv
// rob_wb_fifo: per-requester result buffer with push, pop, head and occupancy count.
module rob_wb_fifo
  import rob_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  t_rob_result                  data_i,
  output t_rob_result                  head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  t_rob_result   mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= data_i;
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/rob_wb_arb.sv
// rob_wb_arb: buffers execution-unit writebacks and delivers one per cycle to the ROB.
// Define ROB_WB_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module rob_wb_arb
  import rob_defs::*;
#(
  parameter int NUM_REQ    = WB_NUM_REQ,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid_rb0,
  input  t_rob_result                req_result_rb0 [NUM_REQ],
  output logic [NUM_REQ-1:0]         req_ready_rb0,
  output logic                       ro_valid_rb0,
  output t_rob_result                ro_result_rb0,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_rb0
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  t_rob_result        head [NUM_REQ];
  logic [CW-1:0]      cnt [NUM_REQ];
  logic [NUM_REQ-1:0] nonempty;
  logic [IDW-1:0]     sel, grant_q;
  logic               any;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_buf
    assign req_ready_rb0[g] = reset && (cnt[g] < CW'(FIFO_DEPTH));
    assign nonempty[g]      = cnt[g] != '0;
    rob_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (req_valid_rb0[g] && req_ready_rb0[g]),
      .pop_i   (any && (sel == IDW'(g))),
      .data_i  (req_result_rb0[g]),
      .head_o  (head[g]),
      .count_o (cnt[g])
    );
  end
`ifdef ROB_WB_ARB_FIXED_PRIO_EN
  always_comb begin
    sel = grant_q;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (nonempty[k]) begin
        sel = IDW'(k);
        any = 1'b1;
      end
  end
`else
  logic [IDW-1:0] last_q;
  // Descending scan so the nearest requester after last grant wins.
  always_comb begin
    sel = grant_q;
    any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (nonempty[(int'(last_q) + k) % NUM_REQ]) begin
        sel = IDW'((int'(last_q) + k) % NUM_REQ);
        any = 1'b1;
      end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_q <= IDW'(NUM_REQ - 1);
    else if (any) last_q <= sel;
`endif
  assign ro_valid_rb0  = any;
  assign ro_result_rb0 = any ? head[sel] : '0;
  assign grant_id_rb0  = any ? sel : grant_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) grant_q <= '0;
    else grant_q <= grant_id_rb0;
`ifdef ASSERT
  always_ff @(posedge clk)
    if (reset) assert ((req_valid_rb0 & ~req_ready_rb0) == '0)
      else $error("rob_wb_arb: request valid while buffer not ready, result dropped");
`endif
endmodule

// File: tb/tb_rob_wb_arb.sv
// tb_rob_wb_arb: random and directed stimulus against a queue-based reference model.
module tb_rob_wb_arb;
  import rob_defs::*;
  localparam int N = 3;
  localparam int D = 2;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] vld = '0;
  logic [N-1:0] rdy;
  logic         ro_v;
  logic [1:0]   gid;
  t_rob_result  res_i [N];
  t_rob_result  ro_r;
  t_rob_result  mq [N][$];
  int last_m = N - 1, gid_m = 0, n_tests = 0, n_fail = 0, seq = 0;
  int gcnt [N];

  always #5 clk = ~clk;

  rob_wb_arb #(.NUM_REQ(N), .FIFO_DEPTH(D)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid_rb0  (vld),
    .req_result_rb0 (res_i),
    .req_ready_rb0  (rdy),
    .ro_valid_rb0   (ro_v),
    .ro_result_rb0  (ro_r),
    .grant_id_rb0   (gid)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    last_m = N - 1;
    gid_m  = 0;
  endtask

  // Called at a falling edge: drive, predict, compare, advance the model, move to next falling edge.
  task automatic step(input logic [N-1:0] v);
    logic [N-1:0] rexp;
    t_rob_result  er;
    int           sel;
    bit           any;
    vld = v;
    for (int i = 0; i < N; i++) begin
      res_i[i].robid = 6'(seq);
      res_i[i].exc   = 1'($urandom);
      res_i[i].data  = $urandom;
      seq++;
    end
    #1;
    any = 1'b0;
    sel = 0;
`ifdef ROB_WB_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++)
      if (!any && mq[i].size() > 0) begin
        sel = i;
        any = 1'b1;
      end
`else
    for (int k = 1; k <= N; k++) begin
      int idx = (last_m + k) % N;
      if (!any && mq[idx].size() > 0) begin
        sel = idx;
        any = 1'b1;
      end
    end
`endif
    for (int i = 0; i < N; i++) rexp[i] = mq[i].size() < D;
    er = any ? mq[sel][0] : '0;
    chk("ready", 64'(rdy), 64'(rexp));
    chk("ro_valid", 64'(ro_v), 64'(any));
    chk("ro_result", 64'(ro_r), 64'(er));
    chk("grant_id", 64'(gid), 64'(any ? sel : gid_m));
    if (ro_v) gcnt[gid]++;
    if (any) begin
      void'(mq[sel].pop_front());
      last_m = sel;
      gid_m  = sel;
    end
    for (int i = 0; i < N; i++)
      if (v[i] && rexp[i]) mq[i].push_back(res_i[i]);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      res_i[i] = '0;
      gcnt[i]  = 0;
    end
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(rdy), 64'(0));
    chk("rst_valid", 64'(ro_v), 64'(0));
    chk("rst_grant", 64'(gid), 64'(0));
    chk("rst_result", 64'(ro_r), 64'(0));
    reset = 1'b1;
    step('1);
    repeat (3) step('0);
    step(3'b010);
    repeat (2) step('0);
    repeat (3) step(3'b100);
    repeat (3) step('1);
    repeat (2) step('1);
    reset = 1'b0;
    #1;
    chk("midrst_valid", 64'(ro_v), 64'(0));
    chk("midrst_ready", 64'(rdy), 64'(0));
    chk("midrst_grant", 64'(gid), 64'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step('1);
    repeat (3) step('0);
    repeat (400) step(N'($urandom));
    repeat (6) step('1);
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    repeat (300) step('1);
    for (int i = 0; i < N; i++)
      chk($sformatf("fair%0d", i), 64'(gcnt[i] >= 99 && gcnt[i] <= 101), 64'(1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
